// File: rtl/mem_arb.sv
// Two-port round-robin arbiter with a bounded lock, sharing one unified memory
// between the CPU (port 0) and a debug/loader master (port 1).
module mem_arb #(
    parameter int AW       = 9,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p1_req,
    input  logic          p0_lock,
    input  logic          p1_lock,
    input  logic          p0_we,
    input  logic          p1_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic [DW-1:0] p1_wdata,
    input  logic [1:0]    p0_whb,
    input  logic [1:0]    p1_whb,
    output logic          p0_gnt,
    output logic          p1_gnt,
    output logic          p0_rvalid,
    output logic          p1_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic [1:0]    mem_whb,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_t;

    localparam logic [3:0] LMAX = 4'(MAX_LOCK);

    own_t       own;
    logic       last;
    logic [3:0] lcnt;

    logic lock_ok0;
    logic lock_ok1;
    logic via_lock;
    logic gnt_lock;

    // An owner keeps the memory until its streak reaches LMAX while the other side waits.
    always_comb begin
        lock_ok0 = (own == OWN0) && p0_req && ((lcnt < LMAX) || !p1_req);
        lock_ok1 = (own == OWN1) && p1_req && ((lcnt < LMAX) || !p0_req);
        via_lock = lock_ok0 || lock_ok1;
        p0_gnt   = 1'b0;
        p1_gnt   = 1'b0;
        if (!rst) begin
            if (lock_ok0) begin
                p0_gnt = 1'b1;
            end else if (lock_ok1) begin
                p1_gnt = 1'b1;
            end else if (p0_req && p1_req) begin
                p0_gnt = last;
                p1_gnt = !last;
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
        end
        gnt_lock = (p0_gnt && p0_lock) || (p1_gnt && p1_lock);
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        mem_whb  = 2'b00;
        if (p0_gnt) begin
            mem_we   = p0_we;
            mem_addr = p0_addr;
            mem_din  = p0_wdata;
            mem_whb  = p0_whb;
        end else if (p1_gnt) begin
            mem_we   = p1_we;
            mem_addr = p1_addr;
            mem_din  = p1_wdata;
            mem_whb  = p1_whb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            own       <= IDLE;
            last      <= 1'b1;
            lcnt      <= 4'd0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else if (p0_gnt || p1_gnt) begin
            last      <= p1_gnt;
            own       <= gnt_lock ? (p1_gnt ? OWN1 : OWN0) : IDLE;
            p0_rvalid <= p0_gnt;
            p1_rvalid <= p1_gnt;
            if (via_lock) begin
                lcnt <= (lcnt >= LMAX) ? LMAX : lcnt + 4'd1;
            end else begin
                lcnt <= 4'd1;
            end
            if (p0_gnt && !p0_we) begin
                p0_rdata <= mem_dout;
            end
            if (p1_gnt && !p1_we) begin
                p1_rdata <= mem_dout;
            end
        end else begin
            own       <= IDLE;
            lcnt      <= 4'd0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus randomized traffic
// compared against a behavioural arbitration/memory model.
module tb_mem_arb;

    localparam int AW       = 9;
    localparam int DW       = 32;
    localparam int MAX_LOCK = 4;

    logic          clk;
    logic          rst;
    logic          p0_req, p1_req, p0_lock, p1_lock, p0_we, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic [1:0]    p0_whb, p1_whb;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [1:0]    mem_whb;
    logic [DW-1:0] mem_dout;

    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    logic [DW-1:0] tb_mem  [512] = '{default: '0};
    logic [DW-1:0] ref_mem [512];

    int tests_run;
    int tests_failed;

    mem_arb #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p1_req(p1_req),
        .p0_lock(p0_lock), .p1_lock(p1_lock),
        .p0_we(p0_we), .p1_we(p1_we),
        .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_whb(p0_whb), .p1_whb(p1_whb),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_whb(mem_whb), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stand-in: combinational read, write on the edge; backdoor port preloads contents.
    assign mem_dout = tb_mem[mem_addr];
    always @(posedge clk) begin
        if (bd_we) tb_mem[bd_addr] <= bd_data;
        else if (mem_we) tb_mem[mem_addr] <= mem_din;
    end

    task automatic drive_idle();
        p0_req = 0; p1_req = 0; p0_lock = 0; p1_lock = 0; p0_we = 0; p1_we = 0;
        p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0; p0_whb = 0; p1_whb = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic backdoor_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bd_we = 1; bd_addr = a; bd_data = d;
        @(posedge clk);
        @(negedge clk);
        bd_we = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        p0_req = 1; p1_req = 1; p0_we = 1; p0_addr = 9'h005; p0_wdata = 32'hA5A5A5A5; p1_we = 0;
        #1;
        tests_run++; if (p0_gnt !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_p0_gnt got %b expected 0", p0_gnt); end
        tests_run++; if (p1_gnt !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_p1_gnt got %b expected 0", p1_gnt); end
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_we got %b expected 0", mem_we); end
        tests_run++; if (mem_addr !== '0) begin tests_failed++; $display("[TB] FAIL reset_mem_addr got %h expected 0", mem_addr); end
        @(posedge clk);
        @(negedge clk);
        rst = 0; p0_we = 0;
        tests_run++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rvalid got %b%b expected 00", p0_rvalid, p1_rvalid); end
        tests_run++; if (p0_rdata !== '0 || p1_rdata !== '0) begin tests_failed++; $display("[TB] FAIL reset_rdata got %h/%h expected 0/0", p0_rdata, p1_rdata); end
        #1;
        tests_run++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin tests_failed++; $display("[TB] FAIL first_tie got p0=%b p1=%b expected p0=1 p1=0", p0_gnt, p1_gnt); end
        @(posedge clk);
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_single_read();
        do_reset();
        backdoor_write(9'h010, 32'hDEADBEEF);
        p1_req = 1; p1_we = 0; p1_addr = 9'h010;
        #1;
        tests_run++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_gnt got p0=%b p1=%b expected p0=0 p1=1", p0_gnt, p1_gnt); end
        tests_run++; if (mem_addr !== 9'h010) begin tests_failed++; $display("[TB] FAIL single_addr got %h expected 010", mem_addr); end
        @(posedge clk);
        @(negedge clk);
        p1_req = 0;
        tests_run++; if (p1_rvalid !== 1'b1 || p0_rvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_rvalid got p0=%b p1=%b expected p0=0 p1=1", p0_rvalid, p1_rvalid); end
        tests_run++; if (p1_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL single_rdata got %h expected deadbeef", p1_rdata); end
        @(posedge clk);
        @(negedge clk);
        tests_run++; if (p1_rvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_rvalid_drop got %b expected 0", p1_rvalid); end
        tests_run++; if (p1_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL single_rdata_hold got %h expected deadbeef", p1_rdata); end
    endtask

    task automatic test_round_robin();
        int expw;
        do_reset();
        @(negedge clk);
        p0_req = 1; p1_req = 1; p0_addr = 9'h010; p1_addr = 9'h011;
        expw = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests_run++; if (p0_gnt !== (expw == 0) || p1_gnt !== (expw == 1)) begin tests_failed++; $display("[TB] FAIL rr_gnt cycle %0d got p0=%b p1=%b expected port %0d", i, p0_gnt, p1_gnt, expw); end
            @(posedge clk);
            @(negedge clk);
            tests_run++; if (p0_rvalid !== (expw == 0) || p1_rvalid !== (expw == 1)) begin tests_failed++; $display("[TB] FAIL rr_rvalid cycle %0d got p0=%b p1=%b expected port %0d", i, p0_rvalid, p1_rvalid, expw); end
            expw = 1 - expw;
        end
        drive_idle();
    endtask

    task automatic test_bounded_lock();
        do_reset();
        @(negedge clk);
        p0_req = 1; p0_lock = 1; p0_addr = 9'h001; p1_req = 1; p1_addr = 9'h002;
        for (int c = 1; c <= MAX_LOCK + 1; c++) begin
            #1;
            tests_run++; if (p0_gnt !== (c <= MAX_LOCK) || p1_gnt !== (c > MAX_LOCK)) begin tests_failed++; $display("[TB] FAIL lock_gnt cycle %0d got p0=%b p1=%b", c, p0_gnt, p1_gnt); end
            @(posedge clk);
            @(negedge clk);
        end
        drive_idle();
    endtask

    task automatic test_write_readback();
        do_reset();
        @(negedge clk);
        p0_req = 1; p0_addr = 9'h001;
        @(posedge clk);
        @(negedge clk);
        p0_addr = 9'h002;
        p1_req = 1; p1_we = 1; p1_lock = 1; p1_addr = 9'h020; p1_wdata = 32'h12345678; p1_whb = 2'b10;
        #1;
        tests_run++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_gnt got p0=%b p1=%b expected p0=0 p1=1", p0_gnt, p1_gnt); end
        tests_run++; if (mem_we !== 1'b1 || mem_din !== 32'h12345678 || mem_whb !== 2'b10) begin tests_failed++; $display("[TB] FAIL wr_lines got we=%b din=%h whb=%b expected 1/12345678/10", mem_we, mem_din, mem_whb); end
        @(posedge clk);
        @(negedge clk);
        p1_we = 0; p1_lock = 0;
        #1;
        tests_run++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin tests_failed++; $display("[TB] FAIL rb_gnt got p0=%b p1=%b expected p0=0 p1=1", p0_gnt, p1_gnt); end
        @(posedge clk);
        @(negedge clk);
        p1_req = 0;
        tests_run++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h12345678) begin tests_failed++; $display("[TB] FAIL rb_rdata got v=%b d=%h expected 1/12345678", p1_rvalid, p1_rdata); end
        tests_run++; if (tb_mem[9'h020] !== 32'h12345678) begin tests_failed++; $display("[TB] FAIL rb_mem got %h expected 12345678", tb_mem[9'h020]); end
        #1;
        tests_run++; if (p0_gnt !== 1'b1) begin tests_failed++; $display("[TB] FAIL rb_p0_after got %b expected 1", p0_gnt); end
        @(posedge clk);
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_midstream_reset();
        do_reset();
        backdoor_write(9'h030, 32'hCAFEF00D);
        p1_req = 1; p1_addr = 9'h030;
        @(posedge clk);
        @(negedge clk);
        p1_req = 0;
        rst = 1;
        p0_req = 1; p0_we = 1; p0_addr = 9'h030; p0_wdata = 32'h11111111; p0_whb = 2'b10;
        #1;
        tests_run++; if (p0_gnt !== 1'b0 || mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_gnt got gnt=%b we=%b expected 0/0", p0_gnt, mem_we); end
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        drive_idle();
        tests_run++; if (p1_rvalid !== 1'b0 || p1_rdata !== '0) begin tests_failed++; $display("[TB] FAIL mid_rst_rvalid got v=%b d=%h expected 0/0", p1_rvalid, p1_rdata); end
        tests_run++; if (tb_mem[9'h030] !== 32'hCAFEF00D) begin tests_failed++; $display("[TB] FAIL mid_rst_mem got %h expected cafef00d", tb_mem[9'h030]); end
    endtask

    // Randomized traffic checked against a plain rule-based model of ownership and memory.
    task automatic test_random(input int n);
        int            owner, lastp, streak, win;
        bit            via;
        bit            rv [2];
        logic [DW-1:0] rd [2];
        bit            q_req [2], q_lock [2], q_we [2], prev_gnt [2];
        logic [AW-1:0] q_addr [2];
        logic [DW-1:0] q_wd [2];
        logic [1:0]    q_whb [2];
        bit            r;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        logic [1:0]    e_whb;

        do_reset();
        for (int i = 0; i < 512; i++) ref_mem[i] = tb_mem[i];
        owner = -1; lastp = 1; streak = 0;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 0; rd[i] = '0; q_req[i] = 0; prev_gnt[i] = 0;
            q_lock[i] = 0; q_we[i] = 0; q_addr[i] = '0; q_wd[i] = '0; q_whb[i] = 0;
        end
        for (int cyc = 0; cyc < n; cyc++) begin
            tests_run++; if (p0_rvalid !== rv[0] || p1_rvalid !== rv[1]) begin tests_failed++; $display("[TB] FAIL rnd_rvalid cycle %0d got %b%b expected %b%b", cyc, p0_rvalid, p1_rvalid, rv[0], rv[1]); end
            tests_run++; if (p0_rdata !== rd[0] || p1_rdata !== rd[1]) begin tests_failed++; $display("[TB] FAIL rnd_rdata cycle %0d got %h/%h expected %h/%h", cyc, p0_rdata, p1_rdata, rd[0], rd[1]); end

            for (int i = 0; i < 2; i++) begin
                if (!(q_req[i] && !prev_gnt[i])) begin
                    q_req[i]  = ($urandom_range(9) < 6);
                    q_lock[i] = 1'($urandom_range(1));
                    q_we[i]   = ($urandom_range(2) == 0);
                    q_addr[i] = 9'($urandom_range(15));
                    q_wd[i]   = $urandom;
                    q_whb[i]  = 2'($urandom_range(3));
                end
            end
            r = ($urandom_range(49) == 0);
            rst = r;
            p0_req = q_req[0]; p0_lock = q_lock[0]; p0_we = q_we[0]; p0_addr = q_addr[0]; p0_wdata = q_wd[0]; p0_whb = q_whb[0];
            p1_req = q_req[1]; p1_lock = q_lock[1]; p1_we = q_we[1]; p1_addr = q_addr[1]; p1_wdata = q_wd[1]; p1_whb = q_whb[1];

            via = 0;
            if (r) win = -1;
            else if (owner >= 0 && q_req[owner] && (streak < MAX_LOCK || !q_req[1-owner])) begin win = owner; via = 1; end
            else if (q_req[0] && q_req[1]) win = 1 - lastp;
            else if (q_req[0]) win = 0;
            else if (q_req[1]) win = 1;
            else win = -1;

            e_we = 0; e_addr = '0; e_din = '0; e_whb = 0;
            if (win >= 0) begin
                e_we = q_we[win]; e_addr = q_addr[win]; e_din = q_wd[win]; e_whb = q_whb[win];
            end
            #1;
            tests_run++; if (p0_gnt !== (win == 0) || p1_gnt !== (win == 1)) begin tests_failed++; $display("[TB] FAIL rnd_gnt cycle %0d got p0=%b p1=%b expected winner %0d", cyc, p0_gnt, p1_gnt, win); end
            tests_run++; if (mem_we !== e_we || mem_addr !== e_addr || mem_din !== e_din || mem_whb !== e_whb) begin tests_failed++; $display("[TB] FAIL rnd_mem cycle %0d got %b/%h/%h/%b expected %b/%h/%h/%b", cyc, mem_we, mem_addr, mem_din, mem_whb, e_we, e_addr, e_din, e_whb); end

            @(posedge clk);
            if (r) begin
                owner = -1; lastp = 1; streak = 0;
                rv[0] = 0; rv[1] = 0; rd[0] = '0; rd[1] = '0;
            end else if (win < 0) begin
                owner = -1; streak = 0; rv[0] = 0; rv[1] = 0;
            end else begin
                lastp  = win;
                owner  = q_lock[win] ? win : -1;
                streak = via ? ((streak + 1 > MAX_LOCK) ? MAX_LOCK : streak + 1) : 1;
                rv[win] = 1; rv[1-win] = 0;
                if (q_we[win]) ref_mem[q_addr[win]] = q_wd[win];
                else rd[win] = ref_mem[q_addr[win]];
            end
            prev_gnt[0] = (win == 0);
            prev_gnt[1] = (win == 1);
            @(negedge clk);
        end
        rst = 0;
        drive_idle();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1;
        bd_we = 0; bd_addr = '0; bd_data = '0;
        drive_idle();
        @(posedge clk);
        test_reset();
        test_single_read();
        test_round_robin();
        test_bounded_lock();
        test_write_readback();
        test_midstream_reset();
        test_random(600);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
